// File: rtl/stack_controller.sv
// Stack front-end: valid/ready push/pop requests, owns the stack pointer and sequences the registered-read pop.
// Optional sticky error (holds until err_clear, blocks requests) is enabled by defining STACK_CTRL_ERR_STICKY_EN.
module stack_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int STACK_BITS = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic [1:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [DATA_WIDTH-1:0] stackPointer,
   output logic [1:0]            stackOp,
   output logic [DATA_WIDTH-1:0] stackData,
   input  logic [DATA_WIDTH-1:0] stackDataIn,
   output logic                  empty,
   output logic                  full,
   output logic                  error,
   input  logic                  err_clear
);

   typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_CAP} state_t;

   localparam logic [DATA_WIDTH-1:0] STACK_DEPTH = DATA_WIDTH'(2 ** STACK_BITS);
   localparam logic [DATA_WIDTH-1:0] ONE         = DATA_WIDTH'(1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] sp_q, sp_d;
   logic [DATA_WIDTH-1:0] stackData_q, stackData_d;
   logic [DATA_WIDTH-1:0] respData_q, respData_d;
   logic                  respValid_q, respValid_d;
   logic                  error_q, error_d;

   logic pushReq;
   logic popReq;
   logic errEvent;

   assign pushReq  = req_valid && req_ready && (req_op == 2'b01);
   assign popReq   = req_valid && req_ready && (req_op == 2'b10);
   assign errEvent = (pushReq && full) || (popReq && empty);

   assign empty        = (sp_q == '0);
   assign full         = (sp_q == STACK_DEPTH);
   assign stackPointer = sp_q;
   assign stackData    = stackData_q;
   assign resp_data    = respData_q;
   assign resp_valid   = respValid_q;
   assign error        = error_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pushReq && !full) begin
               state_d = PUSH;
            end else if (popReq && !empty) begin
               state_d = POP_RD;
            end
         end
         PUSH:    state_d = IDLE;
         POP_RD:  state_d = POP_CAP;
         POP_CAP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Both pop states keep the read strobe up so the memory's registered output is stable during capture.
   always_comb begin
      stackOp = 2'b00;
      case (state_q)
         PUSH:    stackOp = 2'b01;
         POP_RD:  stackOp = 2'b10;
         POP_CAP: stackOp = 2'b10;
         default: stackOp = 2'b00;
      endcase
   end

`ifdef STACK_CTRL_ERR_STICKY_EN
   assign req_ready = (state_q == IDLE) && !error_q;

   always_comb begin
      error_d = error_q;
      if (err_clear) begin
         error_d = 1'b0;
      end else if (errEvent) begin
         error_d = 1'b1;
      end
   end
`else
   logic unusedErrClear;

   assign unusedErrClear = err_clear;
   assign req_ready      = (state_q == IDLE);

   always_comb begin
      error_d = errEvent;
   end
`endif

   always_comb begin
      sp_d        = sp_q;
      stackData_d = stackData_q;
      respData_d  = respData_q;
      respValid_d = 1'b0;
      if ((state_q == IDLE) && pushReq && !full) begin
         stackData_d = req_data;
      end
      if (state_q == PUSH) begin
         sp_d = sp_q + ONE;
      end
      if (state_q == POP_CAP) begin
         sp_d        = sp_q - ONE;
         respData_d  = stackDataIn;
         respValid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp_q        <= '0;
         stackData_q <= '0;
         respData_q  <= '0;
         respValid_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         stackData_q <= stackData_d;
         respData_q  <= respData_d;
         respValid_q <= respValid_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a small registered-read stack_data model (depth 4).
// Sticky-error checks follow STACK_CTRL_ERR_STICKY_EN when it is defined.
module tb_stack_controller;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_data;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [31:0] stackPointer;
   logic [1:0]  stackOp;
   logic [31:0] stackData;
   logic [31:0] stackDataIn;
   logic        empty;
   logic        full;
   logic        error;
   logic        err_clear;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] mem [4];
   logic [31:0] rdIdx;

   stack_controller #(.DATA_WIDTH(32), .STACK_BITS(2)) dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_op(req_op),
      .req_data(req_data),
      .req_ready(req_ready),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .stackPointer(stackPointer),
      .stackOp(stackOp),
      .stackData(stackData),
      .stackDataIn(stackDataIn),
      .empty(empty),
      .full(full),
      .error(error),
      .err_clear(err_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: synchronous write, registered read of STACK[sp-1].
   assign rdIdx = stackPointer - 32'd1;
   always_ff @(posedge clock) begin
      if (stackOp == 2'b01) begin
         mem[stackPointer[1:0]] <= stackData;
      end
      if (stackOp == 2'b10) begin
         stackDataIn <= mem[rdIdx[1:0]];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic doReset();
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_data  = '0;
      err_clear = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Drives one request for a single edge; returns at the negedge of the cycle after the accept edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data);
      checkOutput("ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      req_op    = 2'b00;
   endtask

   task automatic pushWord(input logic [31:0] data);
      applyStimulus(2'b01, data);
      checkOutput("push_op", {30'd0, stackOp}, 32'd1);
      @(negedge clock);
   endtask

   task automatic popWord(input logic [31:0] expected);
      applyStimulus(2'b10, 32'd0);
      checkOutput("pop_rd_op", {30'd0, stackOp}, 32'd2);
      checkOutput("pop_rd_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clock);
      checkOutput("pop_cap_op", {30'd0, stackOp}, 32'd2);
      checkOutput("pop_cap_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clock);
      checkOutput("pop_resp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("pop_resp_data", resp_data, expected);
   endtask

   initial begin
      clock = 1'b0;
      reset = 1'b1;
      req_valid = 1'b0;
      req_op = 2'b00;
      req_data = '0;
      err_clear = 1'b0;
      #2;
      checkOutput("rst_sp", stackPointer, 32'd0);
      checkOutput("rst_op", {30'd0, stackOp}, 32'd0);
      checkOutput("rst_stackdata", stackData, 32'd0);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_resp_data", resp_data, 32'd0);
      checkOutput("rst_error", {31'd0, error}, 32'd0);
      checkOutput("rst_empty", {31'd0, empty}, 32'd1);
      checkOutput("rst_full", {31'd0, full}, 32'd0);
      doReset();
      checkOutput("rel_ready", {31'd0, req_ready}, 32'd1);

      // LIFO ordering
      pushWord(32'h11);
      pushWord(32'h22);
      pushWord(32'h33);
      checkOutput("lifo_sp3", stackPointer, 32'd3);
      popWord(32'h33);
      checkOutput("lifo_sp2", stackPointer, 32'd2);
      popWord(32'h22);
      popWord(32'h11);
      checkOutput("lifo_sp0", stackPointer, 32'd0);
      checkOutput("lifo_empty", {31'd0, empty}, 32'd1);

      // Push timing and exact pop latency
      applyStimulus(2'b01, 32'hA5);
      checkOutput("a5_op", {30'd0, stackOp}, 32'd1);
      checkOutput("a5_sp_during", stackPointer, 32'd0);
      checkOutput("a5_data", stackData, 32'hA5);
      checkOutput("a5_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clock);
      checkOutput("a5_sp_after", stackPointer, 32'd1);
      popWord(32'hA5);
      @(negedge clock);
      checkOutput("a5_strobe_once", {31'd0, resp_valid}, 32'd0);
      checkOutput("a5_data_held", resp_data, 32'hA5);

      // Underflow
      doReset();
      applyStimulus(2'b10, 32'd0);
      checkOutput("uf_error", {31'd0, error}, 32'd1);
      checkOutput("uf_op", {30'd0, stackOp}, 32'd0);
      checkOutput("uf_sp", stackPointer, 32'd0);
`ifdef STACK_CTRL_ERR_STICKY_EN
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checkOutput("uf_sticky_err", {31'd0, error}, 32'd1);
         checkOutput("uf_sticky_ready", {31'd0, req_ready}, 32'd0);
         checkOutput("uf_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
      checkOutput("uf_cleared_err", {31'd0, error}, 32'd0);
      checkOutput("uf_cleared_ready", {31'd0, req_ready}, 32'd1);
      pushWord(32'h77);
      checkOutput("uf_push_sp", stackPointer, 32'd1);
`else
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput("uf_pulse_err", {31'd0, error}, 32'd0);
         checkOutput("uf_no_rd", {30'd0, stackOp}, 32'd0);
         checkOutput("uf_no_resp", {31'd0, resp_valid}, 32'd0);
         checkOutput("uf_ready", {31'd0, req_ready}, 32'd1);
      end
`endif

      // Overflow at depth 4
      doReset();
      pushWord(32'h101);
      pushWord(32'h102);
      pushWord(32'h103);
      checkOutput("of_not_full", {31'd0, full}, 32'd0);
      pushWord(32'h104);
      checkOutput("of_full", {31'd0, full}, 32'd1);
      checkOutput("of_sp4", stackPointer, 32'd4);
      applyStimulus(2'b01, 32'h105);
      checkOutput("of_error", {31'd0, error}, 32'd1);
      checkOutput("of_op", {30'd0, stackOp}, 32'd0);
      checkOutput("of_sp_kept", stackPointer, 32'd4);
`ifdef STACK_CTRL_ERR_STICKY_EN
      @(negedge clock);
      checkOutput("of_sticky_err", {31'd0, error}, 32'd1);
      checkOutput("of_sticky_ready", {31'd0, req_ready}, 32'd0);
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
      checkOutput("of_cleared_err", {31'd0, error}, 32'd0);
`else
      @(negedge clock);
      checkOutput("of_pulse_err", {31'd0, error}, 32'd0);
`endif
      popWord(32'h104);
      checkOutput("of_sp3", stackPointer, 32'd3);

      // Reset during POP_CAP
      doReset();
      pushWord(32'h55);
      pushWord(32'h66);
      applyStimulus(2'b10, 32'd0);
      @(negedge clock);
      checkOutput("ar_cap_op", {30'd0, stackOp}, 32'd2);
      checkOutput("ar_cap_sp", stackPointer, 32'd2);
      #2 reset = 1'b1;
      #1;
      checkOutput("ar_sp", stackPointer, 32'd0);
      checkOutput("ar_op", {30'd0, stackOp}, 32'd0);
      checkOutput("ar_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("ar_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      checkOutput("ar_empty", {31'd0, empty}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
